// File: rtl/ofifo_pkg.sv
// Shared constants and types for the MAC-array output FIFO.
// Defaults match the 8-column array with 16-bit partial sums.
package ofifo_pkg;

    localparam int COL         = 8;
    localparam int PSUM_BW     = 16;
    localparam int OFIFO_DEPTH = 64;

    typedef logic [PSUM_BW-1:0] psum_t;

    function automatic int ptr_bw_f(input int d);
        return $clog2(d) + 1;
    endfunction

endpackage

// File: rtl/ofifo_skew_align_if.sv
// Row handshake between the MAC array / controller and the output FIFO.
// master is the upstream side; slave is the FIFO itself.
interface ofifo_skew_align_if #(
    parameter int col     = 8,
    parameter int psum_bw = 16
);

    logic [col-1:0]         wr;
    logic [psum_bw*col-1:0] in;
    logic                   rd;
    logic [psum_bw*col-1:0] out;
    logic                   o_valid;
    logic                   o_full;
    logic                   o_ready;
    logic [col-1:0]         o_ovf;

    modport master (
        output wr, in, rd,
        input  out, o_valid, o_full, o_ready, o_ovf
    );

    modport slave (
        input  wr, in, rd,
        output out, o_valid, o_full, o_ready, o_ovf
    );

endinterface

// File: rtl/ofifo_col.sv
// Single-column FIFO with wrap-bit pointers and sticky overflow.
// A write into a full column is still accepted when a pop frees a slot.
module ofifo_col
    import ofifo_pkg::*;
#(
    parameter int psum_bw = PSUM_BW,
    parameter int depth   = OFIFO_DEPTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic [psum_bw-1:0] din,
    output logic [psum_bw-1:0] dout,
    output logic               empty,
    output logic               full,
    output logic               ovf
);

    localparam int ptr_bw = ptr_bw_f(depth);
    localparam int aw     = ptr_bw - 1;

    logic [ptr_bw-1:0]  wptr;
    logic [ptr_bw-1:0]  rptr;
    logic [psum_bw-1:0] mem [depth];
    logic               accept;

    assign empty  = (wptr == rptr);
    assign full   = (wptr[aw] != rptr[aw]) &&
                    (wptr[aw-1:0] == rptr[aw-1:0]);
    assign accept = push & (~full | pop);
    assign dout   = mem[rptr[aw-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            ovf  <= 1'b0;
        end else begin
            if (accept)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            if (push & full & ~pop)
                ovf <= 1'b1;
        end
    end

    // Storage has no reset; contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (accept)
            mem[wptr[aw-1:0]] <= din;
    end

endmodule

// File: rtl/ofifo_skew_align.sv
// Per-column FIFOs that absorb the array's column skew and
// release complete aligned rows to the post-processing stage.
module ofifo_skew_align
    import ofifo_pkg::*;
#(
    parameter int col     = COL,
    parameter int psum_bw = PSUM_BW,
    parameter int depth   = OFIFO_DEPTH
) (
    input logic               clk,
    input logic               reset,
    ofifo_skew_align_if.slave bus
);

    logic [col-1:0]         empty;
    logic [col-1:0]         full;
    logic [col-1:0]         ovf;
    logic [psum_bw*col-1:0] dout;
    logic                   valid;
    logic                   pop;

    assign valid = ~|empty;
    assign pop   = bus.rd & valid;

    assign bus.out     = dout;
    assign bus.o_valid = valid;
    assign bus.o_full  = |full;
    assign bus.o_ready = ~|full;
    assign bus.o_ovf   = ovf;

    for (genvar i = 0; i < col; i++) begin : g_col
        ofifo_col #(
            .psum_bw (psum_bw),
            .depth   (depth)
        ) u_col (
            .clk   (clk),
            .reset (reset),
            .push  (bus.wr[i]),
            .pop   (pop),
            .din   (bus.in[psum_bw*i +: psum_bw]),
            .dout  (dout[psum_bw*i +: psum_bw]),
            .empty (empty[i]),
            .full  (full[i]),
            .ovf   (ovf[i])
        );
    end

endmodule

// File: doc/ofifo_skew_align.md
Name: ofifo_skew_align

Overview:
- Output FIFO directly downstream of the MAC array.
- Accepts per-column partial sums on `in`, each column qualified by its own `wr` bit. The array's column valids arrive skewed in time, so the block keeps one FIFO per column.
- Presents aligned full rows (all columns at once) to the post-processing/SFP stage through a valid/pop handshake.
- Detects overflow per column and holds it in sticky error flags.

Parameters:
- col, 8, number of columns / per-column FIFOs
- psum_bw, 16, partial-sum width per column
- depth, 64, entries per column FIFO; must be a power of 2 and at least 2
- ptr_bw, $clog2(depth)+1, pointer width (includes wrap bit); derived, not overridden

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- wr  in  col  per-column write strobe; bit i pushes in[psum_bw*(i+1)-1:psum_bw*i]
- in  in  psum_bw*col  partial sums from the MAC array's south outputs
- rd  in  1  pop one aligned row from all columns
- out  out  psum_bw*col  head entry of every column, first-word-fall-through
- o_valid  out  1  every column non-empty; `out` holds a complete aligned row
- o_full  out  1  any column full
- o_ready  out  1  equals !o_full; upstream may issue execute instructions
- o_ovf  out  col  sticky per-column overflow flag

Behaviour:
- Clocking and reset: all state updates on posedge clk. When reset is high for a cycle, rd/wr pointers=0, o_ovf=0, o_valid=0, o_full=0, o_ready=1. Memory contents are don't-care. `out` is undefined until o_valid=1. Reset mid-stream discards all data with no drain.
- Per-column FIFO i state: wptr_i, rptr_i, each ptr_bw bits wide.
  - empty_i = (wptr_i == rptr_i)
  - full_i = MSBs differ and the low bits are equal
- Pointers increment modulo 2^ptr_bw; the address is the low $clog2(depth) bits. Wrap-around must be seamless.
- Pop:
  - pop = rd & o_valid.
  - All rptr_i advance together on pop.
  - rd while !o_valid is ignored: no pointer change, no flag.
- Push:
  - push_i = wr[i] & (!full_i | pop).
  - Full with a simultaneous pop: the write is accepted in the slot freed that cycle.
  - wr[i] & full_i & !pop: data dropped, o_ovf[i] set to 1; it stays set until reset.
- Simultaneous push and pop on a column: occupancy unchanged, both pointers advance.
- Output timing:
  - out[i] = mem_i[rptr_i addr], combinational read of the registered array.
  - A value written in cycle N appears in out no earlier than cycle N+1.
  - o_valid is AND of !empty_i.
  - o_valid rises in the cycle after the last lagging column's first write.
- Latency: the last-column write to o_valid is 1 cycle. Pop to next row visible is 1 cycle.
- Full-rate operation: rd held high continuously with all columns fed every cycle sustains 1 row/cycle.
- Column-independent writes: any subset of wr may be high in a cycle, including all or none.
- Arithmetic: data is stored bit-exact. No sign extension or accumulation here.

Decomposition:
- Shared package (ofifo_pkg):
  - default constants COL=8, PSUM_BW=16, OFIFO_DEPTH=64
  - PTR_BW helper function
  - psum_t typedef (logic [PSUM_BW-1:0])
- One natural sub-module: ofifo_col, a single-column FIFO.
  - Ports: clk, reset, push, pop, din, dout, empty, full, ovf.
  - Instantiated col times in a generate loop.
- The top level holds only the valid/full reduction and pop fan-out.

Test Plan:
- Skewed fill: col=8, depth=64. Pulse wr[i] at cycle 10+i with in[i]=16'h0100+i → o_valid=0 through cycle 17, o_valid=1 at cycle 18, out = {16'h0107,...,16'h0100}.
- Full-rate streaming: wr=8'hFF every cycle for 200 cycles with values k*8+i, rd held high → every popped row correct and in order, no o_ovf, occupancy never exceeds 2.
- Overflow: write 64 rows with no rd (o_full=1, o_ready=0), then a 65th write on column 3 only → o_ovf=8'h08, the 65th value absent, first pop returns row 0.
- Full with simultaneous pop: 64 rows stored, then wr=8'hFF and rd=1 in the same cycle → o_ovf stays 0, o_full stays 1, the new row is read back 64th after.
- Underflow/wrap: rd=1 with an empty FIFO for 5 cycles → no state change. Then 3 full cycles of 64 push/pop → pointers wrap with data intact.
- Reset mid-operation: 20 rows stored and o_ovf[5]=1, assert reset for 1 cycle → o_valid=0, o_ovf=0, o_ready=1. A following single row reads back correctly.
